// File: rtl/tx_trn_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tx_trn_arbiter_pkg
// Shared definitions for the TRN transmit arbiter:
//   - TRN data/remainder widths and the idle TRN bus values
//   - one-hot arbiter state encoding (ARB_OFFER / ARB_BUSY / ARB_GAP)
//   - next_enabled(): round-robin search for the next enabled requester
// No ports (package).
// ---------------------------------------------------------------------------
package tx_trn_arbiter_pkg;

    localparam int TD_W   = 64;
    localparam int TREM_W = 8;

    localparam logic [TD_W-1:0]   TRN_IDLE_TD     = '0;
    localparam logic [TREM_W-1:0] TRN_IDLE_TREM_N = 8'hFF;

    typedef enum logic [2:0] {
        ARB_OFFER = 3'b001,
        ARB_BUSY  = 3'b010,
        ARB_GAP   = 3'b100
    } arb_state_e;

    // First enabled index strictly after ptr, wrapping at num_req-1 -> 0.
    // If only ptr itself is enabled the search wraps back to ptr; if nothing
    // is enabled ptr is returned unchanged (caller checks |en separately).
    function automatic logic [2:0] next_enabled(input logic [2:0] ptr,
                                                input logic [7:0] en,
                                                input int         num_req);
        logic [2:0] result;
        logic       found;
        int         idx;
        result = ptr;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && (k <= num_req)) begin
                idx = (int'(ptr) + k) % num_req;
                if (en[idx]) begin
                    result = 3'(idx);
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_trn_arbiter_if.sv
// ---------------------------------------------------------------------------
// tx_trn_arbiter_if
// Bundles the requester-side TRN signals and the core-side TRN outputs of the
// transmit arbiter.
//   slave  modport : the arbiter (consumes requester signals, drives core side)
//   master modport : the environment (requesters + core)
// Signals:
//   req_en, driving_interface, td_in, trem_n_in, tsof_n_in, teof_n_in,
//   tsrc_rdy_n_in        : from requesters (requester i in slice i)
//   my_turn              : one-hot offer to requesters
//   trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n : to core
//   owner_idx, protocol_err : status
// ---------------------------------------------------------------------------
interface tx_trn_arbiter_if
    import tx_trn_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]        req_en;
    logic [NUM_REQ-1:0]        my_turn;
    logic [NUM_REQ-1:0]        driving_interface;
    logic [NUM_REQ*TD_W-1:0]   td_in;
    logic [NUM_REQ*TREM_W-1:0] trem_n_in;
    logic [NUM_REQ-1:0]        tsof_n_in;
    logic [NUM_REQ-1:0]        teof_n_in;
    logic [NUM_REQ-1:0]        tsrc_rdy_n_in;

    logic [TD_W-1:0]           trn_td;
    logic [TREM_W-1:0]         trn_trem_n;
    logic                      trn_tsof_n;
    logic                      trn_teof_n;
    logic                      trn_tsrc_rdy_n;
    logic [IDX_W-1:0]          owner_idx;
    logic                      protocol_err;

    modport slave (
        input  req_en, driving_interface, td_in, trem_n_in,
               tsof_n_in, teof_n_in, tsrc_rdy_n_in,
        output my_turn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
               trn_tsrc_rdy_n, owner_idx, protocol_err
    );

    modport master (
        output req_en, driving_interface, td_in, trem_n_in,
               tsof_n_in, teof_n_in, tsrc_rdy_n_in,
        input  my_turn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
               trn_tsrc_rdy_n, owner_idx, protocol_err
    );

endinterface

// File: rtl/tx_trn_arbiter_mux.sv
// ---------------------------------------------------------------------------
// tx_trn_mux
// NUM_REQ-way combinational select of TRN td/trem_n/sof_n/eof_n/src_rdy_n.
// Ports:
//   td_i, trem_n_i, tsof_n_i, teof_n_i, tsrc_rdy_n_i : packed per-requester
//   sel_i   : requester index to forward
//   valid_i : forward only when 1, otherwise drive the idle TRN value
//   *_o     : selected TRN signals
// Built as AND-OR for active-high data and OR-AND for the active-low
// framing, so an unselected or invalid slice can never leak through and the
// no-hit result is exactly the idle value.
// ---------------------------------------------------------------------------
module tx_trn_mux
    import tx_trn_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ*TD_W-1:0]   td_i,
    input  logic [NUM_REQ*TREM_W-1:0] trem_n_i,
    input  logic [NUM_REQ-1:0]        tsof_n_i,
    input  logic [NUM_REQ-1:0]        teof_n_i,
    input  logic [NUM_REQ-1:0]        tsrc_rdy_n_i,
    input  logic [IDX_W-1:0]          sel_i,
    input  logic                      valid_i,
    output logic [TD_W-1:0]           td_o,
    output logic [TREM_W-1:0]         trem_n_o,
    output logic                      tsof_n_o,
    output logic                      teof_n_o,
    output logic                      tsrc_rdy_n_o
);

    logic [NUM_REQ-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit
            assign hit[gi] = valid_i && (sel_i == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        td_o         = TRN_IDLE_TD;
        trem_n_o     = TRN_IDLE_TREM_N;
        tsof_n_o     = 1'b1;
        teof_n_o     = 1'b1;
        tsrc_rdy_n_o = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            td_o         = td_o     | (td_i[i*TD_W +: TD_W]         &  {TD_W{hit[i]}});
            trem_n_o     = trem_n_o & (trem_n_i[i*TREM_W +: TREM_W] | ~{TREM_W{hit[i]}});
            tsof_n_o     = tsof_n_o     & (tsof_n_i[i]     | ~hit[i]);
            teof_n_o     = teof_n_o     & (teof_n_i[i]     | ~hit[i]);
            tsrc_rdy_n_o = tsrc_rdy_n_o & (tsrc_rdy_n_i[i] | ~hit[i]);
        end
    end

endmodule

// File: rtl/tx_trn_arbiter.sv
// ---------------------------------------------------------------------------
// tx_trn_arbiter
// Round-robin owner of the PCIe TRN transmit interface. Offers my_turn to one
// enabled requester at a time for OFFER_CYCLES, holds ownership while that
// requester raises driving_interface, and muxes its TRN signals to the core.
// Ports:
//   trn_clk : TRN clock
//   reset_n : asynchronous active-low reset
//   bus     : tx_trn_arbiter_if.slave (requester inputs, core outputs,
//             my_turn, owner_idx, protocol_err)
// ---------------------------------------------------------------------------
module tx_trn_arbiter
    import tx_trn_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int IDX_W        = $clog2(NUM_REQ),
    parameter int OFFER_CYCLES = 4,
    parameter int MAX_BUSY     = 512
) (
    input  logic           trn_clk,
    input  logic           reset_n,
    tx_trn_arbiter_if.slave bus
);

    localparam int CNT_W  = $clog2(OFFER_CYCLES);
    localparam int BUSY_W = $clog2(MAX_BUSY + 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  own_mask;
    logic                own_drive;
    logic                other_drive;

    assign own_mask    = NUM_REQ'(1) << ptr_q;
    assign own_drive   = |(bus.driving_interface & own_mask);
    assign other_drive = |(bus.driving_interface & ~own_mask);

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_GAP;
            ptr_q      <= '0;
            cnt_q      <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        busy_cnt_d = busy_cnt_q;
        err_d      = err_q;

        // A non-owner driving is an error in every state; it is never muxed.
        if (other_drive) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ARB_OFFER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (own_drive) begin
                    state_d    = ARB_BUSY;
                    busy_cnt_d = '0;
                end else if (cnt_q == CNT_W'(OFFER_CYCLES - 1)) begin
                    state_d = ARB_GAP;
                end
            end
            ARB_BUSY: begin
                if (!own_drive) begin
                    state_d = ARB_GAP;
                end else if (busy_cnt_q == BUSY_W'(MAX_BUSY)) begin
                    // Flag the overrun but keep the owner: cutting the bus
                    // mid-TLP would corrupt the frame at the core.
                    err_d = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + BUSY_W'(1);
                end
            end
            ARB_GAP: begin
                // Requester registered its grab off the last offer cycle.
                if (own_drive) begin
                    state_d    = ARB_BUSY;
                    busy_cnt_d = '0;
                end else if (|bus.req_en) begin
                    ptr_d   = IDX_W'(next_enabled(3'(ptr_q), 8'(bus.req_en), NUM_REQ));
                    cnt_d   = '0;
                    state_d = ARB_OFFER;
                end
            end
            default: begin
                state_d = ARB_GAP;
            end
        endcase
    end

    assign bus.my_turn      = (state_q == ARB_OFFER) ? own_mask : '0;
    assign bus.owner_idx    = ptr_q;
    assign bus.protocol_err = err_q;

    // Gating with reset_n forces the core side idle the instant reset
    // asserts, even if a requester is still holding driving_interface.
    tx_trn_mux #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_mux (
        .td_i         (bus.td_in),
        .trem_n_i     (bus.trem_n_in),
        .tsof_n_i     (bus.tsof_n_in),
        .teof_n_i     (bus.teof_n_in),
        .tsrc_rdy_n_i (bus.tsrc_rdy_n_in),
        .sel_i        (ptr_q),
        .valid_i      (own_drive & reset_n),
        .td_o         (bus.trn_td),
        .trem_n_o     (bus.trn_trem_n),
        .tsof_n_o     (bus.trn_tsof_n),
        .teof_n_o     (bus.trn_teof_n),
        .tsrc_rdy_n_o (bus.trn_tsrc_rdy_n)
    );

endmodule

// File: tb/tb_tx_trn_arbiter.sv
module tb_tx_trn_arbiter;
    import tx_trn_arbiter_pkg::*;

    localparam int NUM_REQ  = 3;
    localparam int IDX_W    = 2;
    localparam int MAX_BUSY = 512;
    localparam logic [74:0] IDLE = {64'h0, 8'hFF, 3'b111};

    logic trn_clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    tx_trn_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus();

    tx_trn_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .OFFER_CYCLES(4), .MAX_BUSY(MAX_BUSY)
    ) dut (
        .trn_clk (trn_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 trn_clk = ~trn_clk;

    logic [74:0] trn_out;
    assign trn_out = {bus.trn_td, bus.trn_trem_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n};

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.driving_interface = '0;
        bus.td_in             = '0;
        bus.trem_n_in         = '1;
        bus.tsof_n_in         = '1;
        bus.teof_n_in         = '1;
        bus.tsrc_rdy_n_in     = '1;
    endtask

    task automatic set_req(input int i, input logic drv, input logic [63:0] td,
                           input logic [7:0] trem, input logic sof_n,
                           input logic eof_n, input logic src_n);
        bus.driving_interface[i]   = drv;
        bus.td_in[64*i +: 64]      = td;
        bus.trem_n_in[8*i +: 8]    = trem;
        bus.tsof_n_in[i]           = sof_n;
        bus.teof_n_in[i]           = eof_n;
        bus.tsrc_rdy_n_in[i]       = src_n;
    endtask

    // Leaves the DUT in GAP with ptr=0, just after a posedge; next tick is k=1.
    task automatic do_reset(input logic [2:0] en);
        reset_n = 1'b0;
        clear_inputs();
        bus.req_en = en;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        bus.req_en = 3'b111;
        set_req(0, 1'b1, 64'hA5A5_A5A5_0000_FFFF, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.my_turn !== 3'b000) begin
            failures++; $display("FAIL reset_my_turn got=%b exp=000", bus.my_turn);
        end
        checks++;
        if (bus.owner_idx !== 2'd0 || bus.protocol_err !== 1'b0) begin
            failures++; $display("FAIL reset_status owner=%0d err=%b exp owner=0 err=0", bus.owner_idx, bus.protocol_err);
        end
        checks++;
        if (trn_out !== IDLE) begin
            failures++; $display("FAIL reset_trn_idle got=%h exp=%h", trn_out, IDLE);
        end
        $display("test_reset done");
    endtask

    task automatic test_rotation();
        int order[3] = '{1, 2, 0};
        logic [2:0] exp;
        do_reset(3'b111);
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp = ((k - 1) % 5 < 4) ? (3'b001 << order[((k - 1) / 5) % 3]) : 3'b000;
            checks++;
            if (bus.my_turn !== exp) begin
                failures++; $display("FAIL rotation_my_turn k=%0d got=%b exp=%b", k, bus.my_turn, exp);
            end
            if (exp != 3'b000) begin
                checks++;
                if (bus.owner_idx !== 2'(order[((k - 1) / 5) % 3])) begin
                    failures++; $display("FAIL rotation_owner k=%0d got=%0d exp=%0d", k, bus.owner_idx, order[((k - 1) / 5) % 3]);
                end
            end
        end
        checks++;
        if (trn_out !== IDLE) begin
            failures++; $display("FAIL rotation_trn_idle got=%h exp=%h", trn_out, IDLE);
        end
        $display("test_rotation done");
    endtask

    task automatic test_tlp();
        do_reset(3'b111);
        // Non-owner junk that must never reach the core.
        set_req(0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b0, 64'hCAFE_F00D_CAFE_F00D, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(); // k=1 offer req1, cnt 0
        tick(); // k=2 offer cycle 2
        set_req(1, 1'b1, 64'h1111_2222_3333_4444, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (trn_out !== {64'h1111_2222_3333_4444, 8'h00, 3'b010} || bus.my_turn !== 3'b010) begin
            failures++; $display("FAIL tlp_beat1 got=%h turn=%b exp=%h turn=010", trn_out, bus.my_turn, {64'h1111_2222_3333_4444, 8'h00, 3'b010});
        end
        tick(); // k=3 BUSY
        checks++;
        if (bus.my_turn !== 3'b000 || bus.owner_idx !== 2'd1) begin
            failures++; $display("FAIL tlp_turn_drop turn=%b owner=%0d exp turn=000 owner=1", bus.my_turn, bus.owner_idx);
        end
        set_req(1, 1'b1, 64'h5555_6666_7777_8888, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (trn_out !== {64'h5555_6666_7777_8888, 8'h00, 3'b110}) begin
            failures++; $display("FAIL tlp_beat2 got=%h exp=%h", trn_out, {64'h5555_6666_7777_8888, 8'h00, 3'b110});
        end
        tick(); // k=4
        set_req(1, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (trn_out !== {64'h9999_AAAA_BBBB_CCCC, 8'h0F, 3'b100}) begin
            failures++; $display("FAIL tlp_beat3 got=%h exp=%h", trn_out, {64'h9999_AAAA_BBBB_CCCC, 8'h0F, 3'b100});
        end
        tick(); // k=5 release, data left on the lanes
        bus.driving_interface[1] = 1'b0;
        #1;
        checks++;
        if (trn_out !== IDLE) begin
            failures++; $display("FAIL tlp_release_idle got=%h exp=%h", trn_out, IDLE);
        end
        tick(); // k=6 GAP
        checks++;
        if (bus.my_turn !== 3'b000) begin
            failures++; $display("FAIL tlp_gap got=%b exp=000", bus.my_turn);
        end
        tick(); // k=7 next offer to req2
        checks++;
        if (bus.my_turn !== 3'b100 || bus.owner_idx !== 2'd2 || bus.protocol_err !== 1'b0) begin
            failures++; $display("FAIL tlp_next_offer turn=%b owner=%0d err=%b exp turn=100 owner=2 err=0", bus.my_turn, bus.owner_idx, bus.protocol_err);
        end
        $display("test_tlp done");
    endtask

    task automatic test_late_grab();
        do_reset(3'b111);
        repeat (14) tick(); // k=14 last offer cycle of req0
        checks++;
        if (bus.my_turn !== 3'b001) begin
            failures++; $display("FAIL late_last_offer got=%b exp=001", bus.my_turn);
        end
        tick(); // k=15 GAP, requester's registered grab appears now
        set_req(0, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (trn_out !== {64'h0123_4567_89AB_CDEF, 8'h00, 3'b010}) begin
            failures++; $display("FAIL late_mirror got=%h exp=%h", trn_out, {64'h0123_4567_89AB_CDEF, 8'h00, 3'b010});
        end
        tick(); // k=16 must be BUSY with owner 0, not an offer to req1
        checks++;
        if (bus.my_turn !== 3'b000 || bus.owner_idx !== 2'd0 || bus.protocol_err !== 1'b0) begin
            failures++; $display("FAIL late_busy turn=%b owner=%0d err=%b exp turn=000 owner=0 err=0", bus.my_turn, bus.owner_idx, bus.protocol_err);
        end
        bus.driving_interface[0] = 1'b0;
        tick(); // k=17 GAP
        tick(); // k=18 offer req1
        checks++;
        if (bus.my_turn !== 3'b010 || bus.owner_idx !== 2'd1) begin
            failures++; $display("FAIL late_next turn=%b owner=%0d exp turn=010 owner=1", bus.my_turn, bus.owner_idx);
        end
        $display("test_late_grab done");
    endtask

    task automatic test_req_en();
        int order[3] = '{2, 0, 2};
        logic [2:0] exp;
        do_reset(3'b101);
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp = ((k - 1) % 5 < 4) ? (3'b001 << order[(k - 1) / 5]) : 3'b000;
            checks++;
            if (bus.my_turn !== exp) begin
                failures++; $display("FAIL req_en_skip k=%0d got=%b exp=%b", k, bus.my_turn, exp);
            end
        end
        bus.req_en = 3'b000; // during offer to req2, window still completes
        for (int k = 12; k <= 20; k++) begin
            tick();
            exp = (k <= 14) ? 3'b100 : 3'b000;
            checks++;
            if (bus.my_turn !== exp) begin
                failures++; $display("FAIL req_en_off k=%0d got=%b exp=%b", k, bus.my_turn, exp);
            end
        end
        checks++;
        if (bus.owner_idx !== 2'd2 || trn_out !== IDLE) begin
            failures++; $display("FAIL req_en_idle owner=%0d trn=%h exp owner=2 trn=%h", bus.owner_idx, trn_out, IDLE);
        end
        $display("test_req_en done");
    endtask

    task automatic test_conflict();
        do_reset(3'b111);
        set_req(0, 1'b1, 64'hAAAA_0000_AAAA_0000, 8'h00, 1'b1, 1'b1, 1'b0);
        tick(); // k=1 BUSY owner 0
        checks++;
        if (bus.protocol_err !== 1'b0 || bus.owner_idx !== 2'd0) begin
            failures++; $display("FAIL conflict_pre err=%b owner=%0d exp err=0 owner=0", bus.protocol_err, bus.owner_idx);
        end
        set_req(2, 1'b1, 64'hBBBB_1111_BBBB_1111, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (trn_out !== {64'hAAAA_0000_AAAA_0000, 8'h00, 3'b110}) begin
            failures++; $display("FAIL conflict_isolation got=%h exp=%h", trn_out, {64'hAAAA_0000_AAAA_0000, 8'h00, 3'b110});
        end
        tick();
        checks++;
        if (bus.protocol_err !== 1'b1) begin
            failures++; $display("FAIL conflict_err got=%b exp=1", bus.protocol_err);
        end
        set_req(2, 1'b0, 64'h0, 8'hFF, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        checks++;
        if (bus.protocol_err !== 1'b1 || trn_out !== {64'hAAAA_0000_AAAA_0000, 8'h00, 3'b110}) begin
            failures++; $display("FAIL conflict_sticky err=%b trn=%h exp err=1", bus.protocol_err, trn_out);
        end
        $display("test_conflict done");
    endtask

    task automatic test_timeout();
        do_reset(3'b111);
        set_req(0, 1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (500) tick();
        checks++;
        if (bus.protocol_err !== 1'b0) begin
            failures++; $display("FAIL timeout_early err=%b exp=0", bus.protocol_err);
        end
        repeat (20) tick();
        checks++;
        if (bus.protocol_err !== 1'b1 || bus.my_turn !== 3'b000) begin
            failures++; $display("FAIL timeout_err err=%b turn=%b exp err=1 turn=000", bus.protocol_err, bus.my_turn);
        end
        checks++;
        if (trn_out !== {64'hC0C0_C0C0_C0C0_C0C0, 8'h00, 3'b110}) begin
            failures++; $display("FAIL timeout_keep_owner got=%h exp=%h", trn_out, {64'hC0C0_C0C0_C0C0_C0C0, 8'h00, 3'b110});
        end
        #2;
        reset_n = 1'b0; // mid-TLP, requester still driving
        #1;
        checks++;
        if (trn_out !== IDLE || bus.my_turn !== 3'b000) begin
            failures++; $display("FAIL midtlp_reset_idle trn=%h turn=%b exp trn=%h turn=000", trn_out, bus.my_turn, IDLE);
        end
        checks++;
        if (bus.protocol_err !== 1'b0 || bus.owner_idx !== 2'd0) begin
            failures++; $display("FAIL midtlp_reset_status err=%b owner=%0d exp err=0 owner=0", bus.protocol_err, bus.owner_idx);
        end
        clear_inputs();
        tick();
        reset_n = 1'b1;
        $display("test_timeout done");
    endtask

    initial begin
        bus.req_en = '0;
        clear_inputs();
        test_reset();
        test_rotation();
        test_tlp();
        test_late_grab();
        test_req_en();
        test_conflict();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
